// File: rtl/axi4_stream_arbiter_rr_if.sv
// ---------------------------------------------------------------------------
// axi4_stream_arbiter_rr_if
// Bundle of AXI4-Stream signals for one or more lanes, used on both sides of
// axi4_stream_arbiter_rr. Lane k occupies bit k of the scalar signals and
// slice k of the vector signals (tdata/tid/tdest).
//
// Parameters:
//   Lanes     - number of streams carried (NumInitiators on the slave side,
//               1 on the master side)
//   DataWidth - tdata bits per lane
//   IdWidth   - tid bits per lane
//   DestWidth - tdest bits per lane
//
// Modports:
//   master - drives tvalid/tdata/tlast/tid/tdest, samples tready
//   slave  - samples tvalid/tdata/tlast/tid/tdest, drives tready
//
// Handshake: a beat transfers on a rising clock edge where tvalid and tready
// of the same lane are both high. A master never waits for tready before
// raising tvalid; tready may depend combinationally on tvalid.
// ---------------------------------------------------------------------------
interface axi4_stream_arbiter_rr_if #(
  parameter int Lanes     = 1,
  parameter int DataWidth = 32,
  parameter int IdWidth   = 4,
  parameter int DestWidth = 4
);
  logic [Lanes-1:0]           tvalid;
  logic [Lanes-1:0]           tready;
  logic [Lanes-1:0]           tlast;
  logic [Lanes*DataWidth-1:0] tdata;
  logic [Lanes*IdWidth-1:0]   tid;
  logic [Lanes*DestWidth-1:0] tdest;

  modport master (output tvalid, tdata, tlast, tid, tdest, input tready);
  modport slave  (input tvalid, tdata, tlast, tid, tdest, output tready);
endinterface

// File: rtl/axi4_stream_arbiter_rr.sv
// ---------------------------------------------------------------------------
// axi4_stream_arbiter_rr
// Round-robin, packet-locked arbiter: NumInitiators AXI4-Stream sources share
// one AXI4-Stream sink. A grant is taken in IDLE (1 cycle latency) and held in
// LOCKED until the granted stream finishes a packet (tlast) or, when
// MaxTransfersPerGrant > 0, until that many beats have been transferred.
// Every release returns to IDLE for exactly one bubble cycle and advances the
// round-robin pointer to the index after the released initiator.
//
// Ports:
//   clk_axis_i - clock, rising edge
//   rst_axis_i - synchronous active-high reset
//   s_axis     - slave modport, NumInitiators lanes (tready driven here)
//   m_axis     - master modport, 1 lane
//   grant_o    - one-hot current grant, zero while idle
//   busy_o     - high while LOCKED; doubles as the FSM state observation
//
// Optional build macro AXI4_STREAM_ARBITER_RR_OUTPUT_REG_EN:
//   m_axis is fed from a 2-entry skid FIFO, so m_axis.tready never reaches
//   s_axis.tready combinationally; adds one cycle of latency, keeps one beat
//   per cycle. Release is judged on the input-side handshake.
//   Without the macro the granted slice is passed straight through.
//
// Handshake: a beat transfers on a rising edge where tvalid and tready are
// both high on the same port; only the granted lane ever sees tready high.
// ---------------------------------------------------------------------------
module axi4_stream_arbiter_rr #(
  parameter int NumInitiators        = 4,
  parameter int TDataWidth           = 32,
  parameter int TIdWidth             = 4,
  parameter int TDestWidth           = 4,
  parameter int MaxTransfersPerGrant = 0
) (
  input  logic                        clk_axis_i,
  input  logic                        rst_axis_i,
  axi4_stream_arbiter_rr_if.slave     s_axis,
  axi4_stream_arbiter_rr_if.master    m_axis,
  output logic [NumInitiators-1:0]    grant_o,
  output logic                        busy_o
);

  localparam int          IdxW       = $clog2(NumInitiators);
  localparam bit          BudgetEn   = (MaxTransfersPerGrant > 0);
  localparam logic [31:0] BudgetLast = BudgetEn ? 32'(MaxTransfersPerGrant - 1) : 32'd0;

  typedef enum logic {IDLE = 1'b0, LOCKED = 1'b1} state_t;

  state_t                   state_q, state_d;
  logic [IdxW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IdxW-1:0]          gidx_q, gidx_d;
  logic [NumInitiators-1:0] grant_q, grant_d;
  logic [31:0]              xfer_cnt_q, xfer_cnt_d;

  logic [IdxW:0]            cand;
  logic [IdxW-1:0]          pick_idx;
  logic                     pick_vld;

  logic                     sel_valid;
  logic                     sel_last;
  logic [TDataWidth-1:0]    sel_data;
  logic [TIdWidth-1:0]      sel_id;
  logic [TDestWidth-1:0]    sel_dest;
  logic                     in_ready;
  logic                     in_hs;
  logic                     budget_hit;
  logic                     release_now;
  logic [NumInitiators-1:0] s_tready;

  // Search rr_ptr, rr_ptr+1, ... (mod N); the first requester wins.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    cand     = '0;
    for (int i = 0; i < NumInitiators; i++) begin
      cand = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(NumInitiators)) cand = cand - (IdxW+1)'(NumInitiators);
      if (!pick_vld && s_axis.tvalid[cand[IdxW-1:0]]) begin
        pick_vld = 1'b1;
        pick_idx = cand[IdxW-1:0];
      end
    end
  end

  // Granted slice; forced to zero while nothing is granted.
  always_comb begin
    sel_valid = 1'b0;
    sel_last  = 1'b0;
    sel_data  = '0;
    sel_id    = '0;
    sel_dest  = '0;
    if (state_q == LOCKED) begin
      sel_valid = s_axis.tvalid[gidx_q];
      sel_last  = s_axis.tlast[gidx_q];
      sel_data  = s_axis.tdata[gidx_q*TDataWidth +: TDataWidth];
      sel_id    = s_axis.tid[gidx_q*TIdWidth +: TIdWidth];
      sel_dest  = s_axis.tdest[gidx_q*TDestWidth +: TDestWidth];
    end
  end

  always_comb begin
    s_tready = '0;
    if (state_q == LOCKED) s_tready[gidx_q] = in_ready;
  end
  assign s_axis.tready = s_tready;

  assign in_hs       = sel_valid & in_ready;
  assign budget_hit  = BudgetEn && (xfer_cnt_q == BudgetLast);
  assign release_now = in_hs & (sel_last | budget_hit);

  // FSM next-state / register updates.
  always_comb begin
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    gidx_d     = gidx_q;
    grant_d    = grant_q;
    xfer_cnt_d = xfer_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (pick_vld) begin
          state_d    = LOCKED;
          gidx_d     = pick_idx;
          grant_d    = NumInitiators'(1) << pick_idx;
          xfer_cnt_d = '0;
        end
      end
      LOCKED: begin
        if (release_now) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = (gidx_q == IdxW'(NumInitiators - 1)) ? '0 : gidx_q + IdxW'(1);
        end else if (in_hs) begin
          xfer_cnt_d = xfer_cnt_q + 32'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_axis_i) begin
    if (rst_axis_i) begin
      state_q    <= IDLE;
      rr_ptr_q   <= '0;
      gidx_q     <= '0;
      grant_q    <= '0;
      xfer_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      rr_ptr_q   <= rr_ptr_d;
      gidx_q     <= gidx_d;
      grant_q    <= grant_d;
      xfer_cnt_q <= xfer_cnt_d;
    end
  end

  assign grant_o = grant_q;
  assign busy_o  = (state_q == LOCKED);

`ifdef AXI4_STREAM_ARBITER_RR_OUTPUT_REG_EN
  typedef struct packed {
    logic [TDataWidth-1:0] data;
    logic                  last;
    logic [TIdWidth-1:0]   id;
    logic [TDestWidth-1:0] dest;
  } beat_t;

  beat_t      fifo_q [2];
  logic       wr_ptr_q, rd_ptr_q;
  logic [1:0] cnt_q;
  logic       pop;

  // Two entries let the input keep accepting while the output stalls for one
  // cycle, so a registered "not full" ready still sustains one beat per cycle.
  assign in_ready = (cnt_q != 2'd2);
  assign pop      = (cnt_q != 2'd0) & m_axis.tready;

  always_ff @(posedge clk_axis_i) begin
    if (rst_axis_i) begin
      fifo_q[0] <= '0;
      fifo_q[1] <= '0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      cnt_q     <= 2'd0;
    end else begin
      if (in_hs) begin
        fifo_q[wr_ptr_q] <= '{data: sel_data, last: sel_last, id: sel_id, dest: sel_dest};
        wr_ptr_q         <= ~wr_ptr_q;
      end
      if (pop) rd_ptr_q <= ~rd_ptr_q;
      if (in_hs && !pop)      cnt_q <= cnt_q + 2'd1;
      else if (!in_hs && pop) cnt_q <= cnt_q - 2'd1;
    end
  end

  assign m_axis.tvalid = (cnt_q != 2'd0);
  assign m_axis.tdata  = (cnt_q != 2'd0) ? fifo_q[rd_ptr_q].data : '0;
  assign m_axis.tlast  = (cnt_q != 2'd0) ? fifo_q[rd_ptr_q].last : 1'b0;
  assign m_axis.tid    = (cnt_q != 2'd0) ? fifo_q[rd_ptr_q].id   : '0;
  assign m_axis.tdest  = (cnt_q != 2'd0) ? fifo_q[rd_ptr_q].dest : '0;
`else
  assign in_ready      = m_axis.tready[0];
  assign m_axis.tvalid = sel_valid;
  assign m_axis.tdata  = sel_data;
  assign m_axis.tlast  = sel_last;
  assign m_axis.tid    = sel_id;
  assign m_axis.tdest  = sel_dest;
`endif

endmodule

// File: tb/tb_axi4_stream_arbiter_rr.sv
// ---------------------------------------------------------------------------
// tb_axi4_stream_arbiter_rr
// Directed bench for axi4_stream_arbiter_rr (default build). Two instances:
// u_dut with unlimited budget and u_bud with MaxTransfersPerGrant = 4.
// Sources are simple counters: lane k sends base+beat*step, tlast every plen
// beats (plen = 0 keeps tlast low); a beat advances when its handshake was
// seen just before the clock edge. Expected outputs are hand-written tables.
// ---------------------------------------------------------------------------
module tb_axi4_stream_arbiter_rr;

  logic clk;
  logic rst;
  logic [3:0] grant, b_grant;
  logic       busy, b_busy;

  axi4_stream_arbiter_rr_if #(.Lanes(4), .DataWidth(32), .IdWidth(4), .DestWidth(4)) s_if ();
  axi4_stream_arbiter_rr_if #(.Lanes(1), .DataWidth(32), .IdWidth(4), .DestWidth(4)) m_if ();
  axi4_stream_arbiter_rr_if #(.Lanes(4), .DataWidth(32), .IdWidth(4), .DestWidth(4)) b_s_if ();
  axi4_stream_arbiter_rr_if #(.Lanes(1), .DataWidth(32), .IdWidth(4), .DestWidth(4)) b_m_if ();

  axi4_stream_arbiter_rr #(.NumInitiators(4), .TDataWidth(32), .TIdWidth(4),
                           .TDestWidth(4), .MaxTransfersPerGrant(0)) u_dut (
    .clk_axis_i (clk),
    .rst_axis_i (rst),
    .s_axis     (s_if.slave),
    .m_axis     (m_if.master),
    .grant_o    (grant),
    .busy_o     (busy)
  );

  axi4_stream_arbiter_rr #(.NumInitiators(4), .TDataWidth(32), .TIdWidth(4),
                           .TDestWidth(4), .MaxTransfersPerGrant(4)) u_bud (
    .clk_axis_i (clk),
    .rst_axis_i (rst),
    .s_axis     (b_s_if.slave),
    .m_axis     (b_m_if.master),
    .grant_o    (b_grant),
    .busy_o     (b_busy)
  );

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- source state ----------------
  int          n_checks = 0;
  int          n_errors = 0;
  logic [3:0]  en, en_b;
  int          bc [4];
  int          plen [4];
  logic [31:0] base [4];
  logic [31:0] step [4];
  int          bc_b [4];
  int          plen_b [4];

  // ---------------- expected tables ----------------
  logic [3:0]  fg [0:18] = '{4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h0,
                             4'h4, 4'h4, 4'h4, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0,
                             4'h1, 4'h1, 4'h1};
  logic [31:0] fd [0:18] = '{32'h00000000, 32'h00000001, 32'h00000002, 32'h0,
                             32'h10000000, 32'h10000001, 32'h10000002, 32'h0,
                             32'h20000000, 32'h20000001, 32'h20000002, 32'h0,
                             32'h30000000, 32'h30000001, 32'h30000002, 32'h0,
                             32'h00000003, 32'h00000004, 32'h00000005};
  logic        fl [0:18] = '{0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 1};

  logic        btr [0:10] = '{1, 1, 0, 1, 0, 1, 0, 1, 1, 1, 1};
  logic [3:0]  bg  [0:10] = '{4'h0, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h4, 4'h0, 4'h4, 4'h4};
  logic        bmv [0:10] = '{0, 1, 1, 1, 1, 1, 1, 1, 0, 1, 0};
  logic [31:0] bd  [0:10] = '{32'h0, 32'habc00b00, 32'habc10b01, 32'habc10b01,
                              32'habc20b02, 32'habc20b02, 32'habc30b03, 32'habc30b03,
                              32'h0, 32'habc40b04, 32'habc50b05};
  logic        bl  [0:10] = '{0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0};

  logic [3:0]  kg [0:6] = '{4'h0, 4'h0, 4'h8, 4'h8, 4'h8, 4'h0, 4'h1};
  logic [31:0] kd [0:6] = '{32'h0, 32'h0, 32'h3d000000, 32'h3d000001, 32'h3d000002,
                            32'h0, 32'h00000006};

  logic [3:0]  ug [0:23] = '{4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2,
                             4'h0, 4'h1, 4'h1, 4'h1, 4'h1, 4'h0, 4'h2, 4'h2, 4'h2, 4'h2,
                             4'h0, 4'h1, 4'h0, 4'h2};
  logic [31:0] ud [0:23] = '{32'h0, 32'h00000000, 32'h00000001, 32'h00000002, 32'h00000003,
                             32'h0, 32'h10000000, 32'h10000001, 32'h10000002, 32'h10000003,
                             32'h0, 32'h00000004, 32'h00000005, 32'h00000006, 32'h00000007,
                             32'h0, 32'h10000004, 32'h10000005, 32'h10000006, 32'h10000007,
                             32'h0, 32'h00000008, 32'h0, 32'h10000008};
  logic        ul [0:23] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0,
                             0, 0, 0, 1, 0, 1, 0, 0};

  // ---------------- driver tasks ----------------
  task automatic drive();
    for (int k = 0; k < 4; k++) begin
      s_if.tvalid[k]          = en[k];
      s_if.tdata[k*32 +: 32]  = base[k] + 32'(bc[k]) * step[k];
      s_if.tlast[k]           = (plen[k] != 0) && ((bc[k] % plen[k]) == plen[k] - 1);
      s_if.tid[k*4 +: 4]      = 4'(k);
      s_if.tdest[k*4 +: 4]    = 4'(k + 5);
      b_s_if.tvalid[k]        = en_b[k];
      b_s_if.tdata[k*32 +: 32] = (32'(k) << 28) + 32'(bc_b[k]);
      b_s_if.tlast[k]         = (plen_b[k] != 0) && ((bc_b[k] % plen_b[k]) == plen_b[k] - 1);
      b_s_if.tid[k*4 +: 4]    = 4'(k);
      b_s_if.tdest[k*4 +: 4]  = 4'(k + 5);
    end
  endtask

  // Advance one clock: beats handshaken before the edge move their source on.
  task automatic tick();
    logic [3:0] hs, hsb;
    hs  = s_if.tvalid & s_if.tready;
    hsb = b_s_if.tvalid & b_s_if.tready;
    @(posedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      if (hs[k] === 1'b1) bc[k]++;
      if (hsb[k] === 1'b1) bc_b[k]++;
    end
    drive();
    #1;
  endtask

  // ---------------- scoreboard ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] idx_of(input logic [3:0] g);
    logic [3:0] r;
    r = 4'd0;
    for (int i = 0; i < 4; i++) if (g[i]) r = 4'(i);
    return r;
  endfunction

  task automatic check_main(input string tag, input logic [3:0] g, input logic [3:0] tr,
                            input logic mv, input logic [31:0] d, input logic l);
    chk({tag, ".grant"},  64'(grant),         64'(g));
    chk({tag, ".busy"},   64'(busy),          64'(g != 4'h0));
    chk({tag, ".tready"}, 64'(s_if.tready),   64'(tr));
    chk({tag, ".tvalid"}, 64'(m_if.tvalid),   64'(mv));
    chk({tag, ".tdata"},  64'(m_if.tdata),    64'(d));
    chk({tag, ".tlast"},  64'(m_if.tlast),    64'(l));
    chk({tag, ".tid"},    64'(m_if.tid),      64'((g != 4'h0) ? idx_of(g) : 4'h0));
    chk({tag, ".tdest"},  64'(m_if.tdest),    64'((g != 4'h0) ? idx_of(g) + 4'd5 : 4'h0));
  endtask

  task automatic check_bud(input string tag, input logic [3:0] g, input logic [31:0] d,
                           input logic l);
    chk({tag, ".grant"},  64'(b_grant),       64'(g));
    chk({tag, ".busy"},   64'(b_busy),        64'(g != 4'h0));
    chk({tag, ".tready"}, 64'(b_s_if.tready), 64'(g));
    chk({tag, ".tvalid"}, 64'(b_m_if.tvalid), 64'(g != 4'h0));
    chk({tag, ".tdata"},  64'(b_m_if.tdata),  64'(d));
    chk({tag, ".tlast"},  64'(b_m_if.tlast),  64'(l));
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst           = 1'b1;
    m_if.tready   = 1'b1;
    b_m_if.tready = 1'b1;
    en            = 4'hf;
    en_b          = 4'h0;
    for (int k = 0; k < 4; k++) begin
      bc[k]     = 0;
      plen[k]   = 3;
      base[k]   = 32'(k) << 28;
      step[k]   = 32'd1;
      bc_b[k]   = 0;
      plen_b[k] = 0;
    end
    drive();

    // Reset held for 3 cycles with every initiator requesting.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_main($sformatf("reset%0d", i), 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);
    end
    rst = 1'b0;

    // Fairness: four requesters, 3-beat packets, sink always ready.
    for (int i = 0; i < 19; i++) begin
      tick();
      check_main($sformatf("fair%0d", i), fg[i], fg[i], fg[i] != 4'h0, fd[i], fl[i]);
    end
    en = 4'h0;
    tick();
    check_main("fair_idle", 4'h0, 4'h0, 1'b0, 32'h0, 1'b0);

    // Backpressure: initiator 2 alone, sink ready toggling; re-grant after
    // the bubble, then tvalid drops mid-packet and the grant must hold.
    base[2] = 32'habc00b00;
    step[2] = 32'h00010001;
    bc[2]   = 0;
    plen[2] = 4;
    for (int j = 0; j < 11; j++) begin
      en = (j == 10) ? 4'h0 : 4'h4;
      tick();
      m_if.tready = btr[j];
      #1;
      check_main($sformatf("bp%0d", j), bg[j], bg[j] & {4{btr[j]}}, bmv[j], bd[j], bl[j]);
    end

    // Mid-packet reset: clear the stuck grant, start a 5-beat packet on 3,
    // reset after beat 2, then initiator 0 must win first.
    rst = 1'b1;
    for (int j = 0; j < 7; j++) begin
      tick();
      check_main($sformatf("mrst%0d", j), kg[j], kg[j], kg[j] != 4'h0, kd[j], 1'b0);
      if (j == 0) begin
        rst         = 1'b0;
        en          = 4'h8;
        base[3]     = 32'h3d000000;
        bc[3]       = 0;
        plen[3]     = 5;
        m_if.tready = 1'b1;
      end
      if (j == 4) begin
        rst = 1'b1;
        en  = 4'h9;
      end
      if (j == 5) rst = 1'b0;
    end
    en = 4'h0;

    // Budget of 4 on u_bud: tlast low alternates 0,1 every 4 beats; then a
    // tlast coinciding with budget expiry and a single-beat packet.
    en_b = 4'h3;
    for (int i = 0; i < 24; i++) begin
      if (i == 15) begin
        plen_b[0] = 1;
        plen_b[1] = 4;
      end
      tick();
      check_bud($sformatf("budget%0d", i), ug[i], ud[i], ul[i]);
    end
    en_b = 4'h0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
